// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------------+
// | mult_pkg                                                                   |
// | Shared widths, limb-count clamp and state encoding for the multiplier      |
// | datapath pack/unpack stages.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

    localparam int LIMB_W    = 16;
    localparam int WORD_W    = 64;
    localparam int NUM_LIMBS = WORD_W / LIMB_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A limb count of zero or anything above the word's capacity means "whole word".
    function automatic logic [2:0] clamp_nlimbs(input logic [2:0] i_n);
        if ((i_n == 3'd0) || (i_n > 3'(NUM_LIMBS))) begin
            return 3'(NUM_LIMBS);
        end
        return i_n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right_limb.sv
// +----------------------------------------------------------------------------+
// | shift_right_limb                                                           |
// | Combinational logical right shift of a word by one limb, zero filled.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_right_limb
    import mult_pkg::*;
#(
    parameter int P_WORD_W = WORD_W,
    parameter int P_LIMB_W = LIMB_W
) (
    input  logic [P_WORD_W-1:0] i_data,
    output logic [P_WORD_W-1:0] o_data
);

    assign o_data = i_data >> P_LIMB_W;

endmodule

`default_nettype wire

// File: rtl/limb_unpacker_64to16.sv
// +----------------------------------------------------------------------------+
// | limb_unpacker_64to16                                                       |
// | Emits a 64-bit product word as 16-bit limbs, LSB first, with valid/ready   |
// | on both sides. Optional LIMB_UNPACK_PARITY_EN adds registered out_par.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module limb_unpacker_64to16
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [2:0]        in_nlimbs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic              out_last,
`ifdef LIMB_UNPACK_PARITY_EN
    output logic              out_par,
`endif
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [WORD_W-1:0] w_shifted;
    logic [2:0]        r_remaining;
    logic [2:0]        w_remaining_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [2:0]        w_nlimbs;
    logic              w_accept;
    logic              w_fire;

    shift_right_limb #(
        .P_WORD_W (WORD_W),
        .P_LIMB_W (LIMB_W)
    ) u_shift (
        .i_data (r_shift),
        .o_data (w_shifted)
    );

    assign out_valid = (r_state == SHIFT);
    assign busy      = (r_state == SHIFT);
    assign out_data  = r_shift[LIMB_W-1:0];
    assign out_idx   = r_idx;
    assign out_last  = r_last;

    // Accepting during the final limb keeps the bus free of bubbles between words.
    assign w_fire    = out_valid & out_ready;
    assign in_ready  = (r_state == IDLE) | (w_fire & r_last);
    assign w_accept  = in_valid & in_ready;
    assign w_nlimbs  = clamp_nlimbs(in_nlimbs);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_remaining_nxt = r_remaining;
        w_idx_nxt       = r_idx;
        w_last_nxt      = r_last;
        if (w_accept) begin
            w_state_nxt     = SHIFT;
            w_shift_nxt     = in_data;
            w_remaining_nxt = w_nlimbs;
            w_idx_nxt       = 2'd0;
            w_last_nxt      = (w_nlimbs == 3'd1);
        end else if (w_fire && !r_last) begin
            w_shift_nxt     = w_shifted;
            w_remaining_nxt = r_remaining - 3'd1;
            w_idx_nxt       = r_idx + 2'd1;
            w_last_nxt      = (r_remaining == 3'd2);
        end else if (w_fire) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = 3'd0;
            w_last_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_remaining <= 3'd0;
            r_idx       <= 2'd0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_remaining <= w_remaining_nxt;
            r_idx       <= w_idx_nxt;
            r_last      <= w_last_nxt;
        end
    end

`ifdef LIMB_UNPACK_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else begin
            r_par <= ^w_shift_nxt[LIMB_W-1:0];
        end
    end

    assign out_par = r_par;
`endif

endmodule

`default_nettype wire
